// File: rtl/alu_sequencer_if.sv
// Request-side valid/ready handshake into the ALU sequencer.
// The master presents an opcode and two operands; the slave answers with req_ready.
interface alu_sequencer_if;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 32;

  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;

  modport master (output req_valid, output req_op, output req_a, output req_b,
                  input  req_ready);
  modport slave  (input  req_valid, input  req_op, input  req_a, input  req_b,
                  output req_ready);
endinterface

// File: rtl/alu_sequencer.sv
// Issue controller for a combinational ALU: latches one operation, holds it stable
// for an opcode-dependent number of cycles, then captures the 64-bit result into Z.
module alu_sequencer #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic               clock,
  input  logic               clear,
  alu_sequencer_if.slave     req,
  output logic [31:0]        alu_a,
  output logic [31:0]        alu_b,
  output logic [3:0]         alu_op,
  input  logic [63:0]        alu_result,
  output logic [31:0]        z_hi,
  output logic [31:0]        z_lo,
  output logic               done,
  output logic               busy,
  output logic               dz_flag,
  output logic               ill_flag
);
  localparam int unsigned CNT_W  = 8;
  localparam logic [3:0]  OP_MUL = 4'd6;
  localparam logic [3:0]  OP_DIV = 4'd7;
  localparam logic [3:0]  OP_ILL = 4'd13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic               ready_q;
  logic               accept_c;

  // Remaining hold cycles after the first EXEC cycle; only MUL/DIV are multicycle.
  function automatic logic [CNT_W-1:0] hold_count(input logic [3:0] op);
    case (op)
      OP_MUL:  return CNT_W'(MUL_CYCLES - 1);
      OP_DIV:  return CNT_W'(DIV_CYCLES - 1);
      default: return '0;
    endcase
  endfunction

  assign req.req_ready = ready_q;
  assign accept_c      = req.req_valid && ready_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= IDLE;
      count    <= '0;
      ready_q  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      z_hi     <= '0;
      z_lo     <= '0;
      dz_flag  <= 1'b0;
      ill_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (accept_c) begin
            alu_a   <= req.req_a;
            alu_b   <= req.req_b;
            alu_op  <= req.req_op;
            count   <= hold_count(req.req_op);
            state   <= EXEC;
            ready_q <= 1'b0;
            busy    <= 1'b1;
          end else begin
            state   <= IDLE;
            ready_q <= 1'b1;
            busy    <= 1'b0;
          end
        end
        EXEC: begin
          // ALU inputs stay untouched here so multicycle paths see a stable source.
          if (count == '0) begin
            z_hi     <= alu_result[63:32];
            z_lo     <= alu_result[31:0];
            dz_flag  <= (alu_op == OP_DIV) && (alu_b == '0);
            ill_flag <= (alu_op >= OP_ILL);
            state    <= DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            ready_q  <= 1'b1;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU in the loop, directed vector table,
// multi-cycle corner sequences and randomized ops against a rule-based model.
module tb_alu_sequencer;
  localparam int unsigned MUL_L = 4;
  localparam int unsigned DIV_L = 8;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] alu_a, alu_b, z_hi, z_lo;
  logic [3:0]  alu_op;
  logic [63:0] alu_result;
  logic        done, busy, dz_flag, ill_flag;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;

  always #5 clock = ~clock;

  alu_sequencer_if rif ();

  alu_sequencer #(.MUL_CYCLES(MUL_L), .DIV_CYCLES(DIV_L)) dut (
    .clock      (clock),
    .clear      (clear),
    .req        (rif),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .z_hi       (z_hi),
    .z_lo       (z_lo),
    .done       (done),
    .busy       (busy),
    .dz_flag    (dz_flag),
    .ill_flag   (ill_flag)
  );

  // Behavioural ALU; divide by zero returns {A, all-ones}, illegal ops return {A, B}.
  function automatic logic [63:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] da, db;
    logic [31:0] q, r;
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'd0:  return {32'h0, a | b};
      4'd1:  return {32'h0, a & b};
      4'd2:  return {32'h0, ~a};
      4'd3:  return {32'h0, 32'(a + b)};
      4'd4:  return {32'h0, 32'(a - b)};
      4'd5:  return {32'h0, 32'(32'd0 - a)};
      4'd6: begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return 64'(sa * sb);
      end
      4'd7: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        da = a;
        db = b;
        q = 32'(da / db);
        r = 32'(da % db);
        return {r, q};
      end
      4'd8:  return {32'h0, a << sh};
      4'd9:  return {32'h0, a >> sh};
      4'd10: return {32'h0, 32'($signed(a) >>> sh)};
      4'd11: return {32'h0, (a << sh) | (a >> (6'd32 - {1'b0, sh}))};
      4'd12: return {32'h0, (a >> sh) | (a << (6'd32 - {1'b0, sh}))};
      default: return {a, b};
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_op, alu_a, alu_b);

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  function automatic int exp_lat(input logic [3:0] op);
    if (op == 4'd6) return MUL_L;
    if (op == 4'd7) return DIV_L;
    return 1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_alu_ab"}, {alu_a, alu_b}, 64'h0);
    check({tag, "_alu_op"}, 64'(alu_op), 64'h0);
    check({tag, "_z"}, {z_hi, z_lo}, 64'h0);
    check({tag, "_ctl"}, 64'({done, busy, dz_flag, ill_flag, rif.req_ready}), 64'h1);
  endtask

  // Issue one op, wait for done; returns edges from accept to done and whether
  // the ALU inputs stayed equal to the request throughout.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit hold_valid,
                        output int lat, output bit held_ok);
    int w;
    rif.req_valid = 1'b1;
    rif.req_op    = op;
    rif.req_a     = a;
    rif.req_b     = b;
    w = 0;
    while (!rif.req_ready && w < 50) begin
      step();
      w++;
    end
    if (!rif.req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_accept_timeout: req_ready still 0 after %0d cycles", tag, w);
    end
    step();
    if (!hold_valid) rif.req_valid = 1'b0;
    check({tag, "_exec_ctl"}, 64'({busy, rif.req_ready, done}), 64'h4);
    held_ok = 1'b1;
    lat = 0;
    while (!done && lat < 300) begin
      if (alu_a !== a || alu_b !== b || alu_op !== op) held_ok = 1'b0;
      step();
      lat++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_done_timeout: no done after %0d cycles", tag, lat);
    end
    if (alu_a !== a || alu_b !== b || alu_op !== op) held_ok = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat;
    bit hok;
    int d1, d2;
    logic [3:0] op;
    logic [31:0] a, b;

    vecs.push_back('{4'd3,  32'd5,          32'd7,          32'h0,        32'd12,       1'b0, 1'b0, 1});
    vecs.push_back('{4'd6,  32'hFFFF_FFFF,  32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 4});
    vecs.push_back('{4'd7,  32'd17,         32'd5,          32'd2,        32'd3,        1'b0, 1'b0, 8});
    vecs.push_back('{4'd7,  32'd9,          32'd0,          32'd9,        32'hFFFF_FFFF, 1'b1, 1'b0, 8});
    vecs.push_back('{4'd0,  32'hF0,         32'h0F,         32'h0,        32'hFF,       1'b0, 1'b0, 1});
    vecs.push_back('{4'd1,  32'hF0,         32'h3C,         32'h0,        32'h30,       1'b0, 1'b0, 1});
    vecs.push_back('{4'd2,  32'h0,          32'h5,          32'h0,        32'hFFFF_FFFF, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd4,  32'd3,          32'd5,          32'h0,        32'hFFFF_FFFE, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd5,  32'd1,          32'd0,          32'h0,        32'hFFFF_FFFF, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd8,  32'd1,          32'd4,          32'h0,        32'h10,       1'b0, 1'b0, 1});
    vecs.push_back('{4'd9,  32'h8000_0000,  32'd4,          32'h0,        32'h0800_0000, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd10, 32'h8000_0000,  32'd4,          32'h0,        32'hF800_0000, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd11, 32'h8000_0001,  32'd1,          32'h0,        32'h3,        1'b0, 1'b0, 1});
    vecs.push_back('{4'd12, 32'd1,          32'd1,          32'h0,        32'h8000_0000, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd6,  32'hFFFF_FFF9,  32'd6,          32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, 1'b0, 4});
    vecs.push_back('{4'd7,  32'hFFFF_FFEF,  32'd5,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b0, 8});
    vecs.push_back('{4'd13, 32'hAB,         32'hCD,         32'hAB,       32'hCD,       1'b0, 1'b1, 1});
    vecs.push_back('{4'd15, 32'h1234,       32'h0,          32'h1234,     32'h0,        1'b0, 1'b1, 1});

    clear = 1'b1;
    rif.req_valid = 1'b0;
    rif.req_op = '0;
    rif.req_a = '0;
    rif.req_b = '0;
    step();
    step();
    clear = 1'b0;
    check_cleared("reset");

    // ADD with req_valid held: re-accepted only in the DONE cycle.
    run_op("add_hold", 4'd3, 32'd5, 32'd7, 1'b1, lat, hok);
    check("add_hold_lat", 64'(lat), 64'd1);
    check("add_hold_z", {z_hi, z_lo}, 64'd12);
    check("add_hold_flags", 64'({dz_flag, ill_flag}), 64'h0);
    check("add_hold_ready_in_done", 64'(rif.req_ready), 64'h1);
    step();
    rif.req_valid = 1'b0;
    check("add_reaccept_busy", 64'({busy, done}), 64'h2);
    step();
    check("add_reaccept_done", 64'(done), 64'h1);
    step();
    check("done_one_cycle", 64'({done, busy, rif.req_ready}), 64'h1);

    // Directed vector table.
    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat, hok);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d_z", i), {z_hi, z_lo}, {vecs[i].hi, vecs[i].lo});
      check($sformatf("vec%0d_flags", i), 64'({dz_flag, ill_flag}),
            64'({vecs[i].dz, vecs[i].ill}));
      check($sformatf("vec%0d_hold", i), 64'(hok), 64'h1);
      step();
    end

    // Back-to-back: AND, then illegal op 14 accepted in the DONE cycle.
    run_op("b2b_and", 4'd1, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, lat, hok);
    d1 = cyc;
    check("b2b_and_z", {z_hi, z_lo}, 64'h0000_0000_0F00_0F00);
    run_op("b2b_ill", 4'd14, 32'h5555_0001, 32'h0000_AAAA, 1'b0, lat, hok);
    d2 = cyc;
    check("b2b_spacing", 64'(d2 - d1), 64'd2);
    check("b2b_ill_z", {z_hi, z_lo}, 64'h5555_0001_0000_AAAA);
    check("b2b_ill_flags", 64'({dz_flag, ill_flag}), 64'h1);
    step();

    // Two-cycle clear in the middle of a MUL.
    rif.req_valid = 1'b1;
    rif.req_op = 4'd6;
    rif.req_a = 32'd100;
    rif.req_b = 32'd200;
    step();
    rif.req_valid = 1'b0;
    step();
    clear = 1'b1;
    step();
    step();
    clear = 1'b0;
    check_cleared("midmul_clear");

    // Clear during cycle T+4 of a DIV: that op never completes.
    done_cnt = 0;
    rif.req_valid = 1'b1;
    rif.req_op = 4'd7;
    rif.req_a = 32'd1000;
    rif.req_b = 32'd7;
    step();
    rif.req_valid = 1'b0;
    step();
    step();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_cleared("middiv_clear");
    run_op("post_clear_add", 4'd3, 32'd1, 32'd1, 1'b0, lat, hok);
    check("post_clear_add_z", {z_hi, z_lo}, 64'd2);
    check("post_clear_add_lat", 64'(lat), 64'd1);
    step();
    for (int k = 0; k < 12; k++) step();
    check("middiv_no_done", 64'(done_cnt), 64'd1);

    // Randomized ops checked against the rules: z is the ALU value, latency by opcode.
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40));
      run_op("rnd", op, a, b, 1'b0, lat, hok);
      check($sformatf("rnd%0d_lat op%0d", i, op), 64'(lat), 64'(exp_lat(op)));
      check($sformatf("rnd%0d_z op%0d", i, op), {z_hi, z_lo}, alu_fn(op, a, b));
      check($sformatf("rnd%0d_flags op%0d", i, op), 64'({dz_flag, ill_flag}),
            64'({(op == 4'd7) && (b == 32'd0), op >= 4'd13}));
      check($sformatf("rnd%0d_hold", i), 64'(hok), 64'h1);
      if ($urandom_range(0, 1) == 1) begin
        step();
        check($sformatf("rnd%0d_pulse", i), 64'({done, rif.req_ready}), 64'h1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
